// File: rtl/sram_pkg.sv
// Shared types for the SRAM result writer: controller state encoding and extension modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // SIGN_EXT parameter values
    localparam int EXT_ZERO = 0;
    localparam int EXT_SIGN = 1;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with show-ahead head word and full/empty flags.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: push is dropped when full, pop is ignored when empty; push+pop together both apply.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/sram_result_writer.sv
// Buffers a result stream and bursts it into an SRAM, plus single-word readback.
// Latency: write strobe the cycle after a word is buffered; readback 3 cycles rd_req->rd_valid with ry=1.
// Backpressure: in_ready drops when the FIFO is full or the burst count is reached; ry=0 stalls strobes.
module sram_result_writer
    import sram_pkg::*;
#(
    parameter int RES_W      = 18,
    parameter int MEM_W      = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SIGN_EXT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [MEM_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              we_n,
    output logic [ADDR_W-1:0] address,
    output logic [MEM_W-1:0]  write_data,
    input  logic [MEM_W-1:0]  read_data,
    input  logic              ry
);
    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    remaining;
    logic [ADDR_W:0]    count_q;
    logic [ADDR_W:0]    accepted;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [MEM_W-1:0]   wdata_q;
    logic [RES_W-1:0]   fifo_head;
    logic [MEM_W-1:0]   ext_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               wr_strobe;
    logic               rd_strobe;

    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (wr_strobe),
        .din   (in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Widen the FIFO head to the SRAM word, copying the result MSB when sign-extending.
    always_comb begin
        ext_head = '0;
        ext_head[RES_W-1:0] = fifo_head;
        for (int i = RES_W; i < MEM_W; i++) begin
            ext_head[i] = (SIGN_EXT == EXT_SIGN) ? fifo_head[RES_W-1] : 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start takes priority over rd_req, both ignored outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? ST_DONE : ST_WRITE;
                end else if (rd_req) begin
                    state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_strobe && remaining == (ADDR_W+1)'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_READ:      if (ry) state_nxt = ST_READ_WAIT;
            ST_READ_WAIT: if (ry) state_nxt = ST_IDLE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // SRAM strobes and status; everything is gated by rst so a reset cycle never strobes.
    always_comb begin
        wr_strobe  = !rst && (state == ST_WRITE) && !fifo_empty && ry;
        rd_strobe  = !rst && (state == ST_READ) && ry;
        cs_n       = !(wr_strobe || rd_strobe);
        we_n       = !wr_strobe;
        address    = wr_strobe ? ptr : (rd_strobe ? rd_addr_q : addr_q);
        write_data = wr_strobe ? ext_head : wdata_q;
        in_ready   = !rst && (state == ST_WRITE) && !fifo_full && (accepted < count_q);
        busy       = !rst && (state != ST_IDLE);
        done       = !rst && (state == ST_DONE);
    end

    // Burst/readback datapath: pointers, counters, held bus values and readback capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            count_q   <= '0;
            accepted  <= '0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == ST_IDLE && start) begin
                ptr       <= base_addr;
                remaining <= count;
                count_q   <= count;
                accepted  <= '0;
            end else if (state == ST_IDLE && rd_req) begin
                rd_addr_q <= rd_addr;
            end
            if (fifo_push) begin
                accepted <= accepted + (ADDR_W+1)'(1);
            end
            if (wr_strobe) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
                addr_q    <= ptr;
                wdata_q   <= ext_head;
            end
            if (rd_strobe) begin
                addr_q <= rd_addr_q;
            end
            if (state == ST_READ_WAIT && ry) begin
                rd_data  <= read_data;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_result_writer.sv
// Testbench for sram_result_writer: zero- and sign-extending instances on shared stimulus.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: ry and in_valid driven directly by the vectors and sequences.
module tb_sram_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  count;
    logic        in_valid;
    logic [17:0] in_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [31:0] read_data;
    logic        ry;

    logic        in_ready, rd_valid, busy, done, cs_n, we_n;
    logic [31:0] rd_data, write_data;
    logic [7:0]  address;

    logic        sx_in_ready, sx_rd_valid, sx_busy, sx_done, sx_cs_n, sx_we_n;
    logic [31:0] sx_rd_data, sx_write_data;
    logic [7:0]  sx_address;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_result_writer #(.SIGN_EXT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .cs_n(cs_n), .we_n(we_n), .address(address),
        .write_data(write_data), .read_data(read_data), .ry(ry)
    );

    sram_result_writer #(.SIGN_EXT(1)) dut_sx (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(sx_in_ready), .in_data(in_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(sx_rd_valid), .rd_data(sx_rd_data),
        .busy(sx_busy), .done(sx_done), .cs_n(sx_cs_n), .we_n(sx_we_n), .address(sx_address),
        .write_data(sx_write_data), .read_data(read_data), .ry(ry)
    );

    typedef struct {
        logic [31:0] rst, start, base, cnt, iv, id, rq, ra, ry, rdat;
        logic [31:0] csn, wen, addr, wd, wdsx, irdy, busy, done, rvld, rdd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        in_data = '0; rd_req = 1'b0; rd_addr = '0; read_data = '0; ry = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, acc, strobes, seen_done;
        logic last_irdy;
        logic [7:0]  got_addr[$];
        logic [31:0] got_data[$];

        //          rst st base   cnt iv id        rq ra     ry rdat           csn wen addr  wd            wdsx          irdy busy done rvld rdd
        tbl.push_back('{1, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h00, 'h0,          'h0,          0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 1, 'hFE, 4, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h00, 'h0,          'h0,          0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 1, 'h1,     0, 'h00,  1, 'h0,           1, 1, 'h00, 'h0,          'h0,          1, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 1, 'h2,     0, 'h00,  1, 'h0,           0, 0, 'hFE, 'h1,          'h1,          1, 1, 0, 0, 'h0});
        tbl.push_back('{0, 1, 'h55, 9, 1, 'h3,     0, 'h00,  1, 'h0,           0, 0, 'hFF, 'h2,          'h2,          1, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 1, 'h4,     0, 'h00,  1, 'h0,           0, 0, 'h00, 'h3,          'h3,          1, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           0, 0, 'h01, 'h4,          'h4,          0, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h01, 'h4,          'h4,          0, 1, 1, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h01, 'h4,          'h4,          0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 1, 'h20, 1, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h01, 'h4,          'h4,          0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 1, 'h20000, 0, 'h00,  1, 'h0,           1, 1, 'h01, 'h4,          'h4,          1, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 1, 'h3,     0, 'h00,  1, 'h0,           0, 0, 'h20, 'h00020000,   'hFFFE0000,   0, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h20, 'h00020000,   'hFFFE0000,   0, 1, 1, 0, 'h0});
        tbl.push_back('{0, 1, 'h00, 0, 0, 'h0,     1, 'h77,  1, 'h0,           1, 1, 'h20, 'h00020000,   'hFFFE0000,   0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h20, 'h00020000,   'hFFFE0000,   0, 1, 1, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     1, 'h10,  1, 'h0,           1, 1, 'h20, 'h00020000,   'hFFFE0000,   0, 0, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           0, 1, 'h10, 'h00020000,   'hFFFE0000,   0, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'hCAFEF00D,    1, 1, 'h10, 'h00020000,   'hFFFE0000,   0, 1, 0, 0, 'h0});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h10, 'h00020000,   'hFFFE0000,   0, 0, 0, 1, 'hCAFEF00D});
        tbl.push_back('{0, 0, 'h00, 0, 0, 'h0,     0, 'h00,  1, 'h0,           1, 1, 'h10, 'h00020000,   'hFFFE0000,   0, 0, 0, 0, 'hCAFEF00D});

        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();

        // Vector table: burst with address wrap, ignored start, extension, count=0, readback.
        foreach (tbl[i]) begin
            rst       = tbl[i].rst[0];
            start     = tbl[i].start[0];
            base_addr = tbl[i].base[7:0];
            count     = tbl[i].cnt[8:0];
            in_valid  = tbl[i].iv[0];
            in_data   = tbl[i].id[17:0];
            rd_req    = tbl[i].rq[0];
            rd_addr   = tbl[i].ra[7:0];
            ry        = tbl[i].ry[0];
            read_data = tbl[i].rdat;
            @(negedge clk);
            chk($sformatf("r%0d cs_n", i),       32'(cs_n),       tbl[i].csn);
            chk($sformatf("r%0d we_n", i),       32'(we_n),       tbl[i].wen);
            chk($sformatf("r%0d address", i),    32'(address),    tbl[i].addr);
            chk($sformatf("r%0d write_data", i), write_data,      tbl[i].wd);
            chk($sformatf("r%0d sx_wdata", i),   sx_write_data,   tbl[i].wdsx);
            chk($sformatf("r%0d in_ready", i),   32'(in_ready),   tbl[i].irdy);
            chk($sformatf("r%0d busy", i),       32'(busy),       tbl[i].busy);
            chk($sformatf("r%0d done", i),       32'(done),       tbl[i].done);
            chk($sformatf("r%0d rd_valid", i),   32'(rd_valid),   tbl[i].rvld);
            chk($sformatf("r%0d rd_data", i),    rd_data,         tbl[i].rdd);
            next_cycle();
        end

        // Backpressure: ry low for 10 cycles, then drain a 6-word burst at 0x40.
        idle_inputs();
        start = 1'b1; base_addr = 8'h40; count = 9'd6; ry = 1'b0;
        next_cycle();
        start = 1'b0;
        sent = 0; strobes = 0; last_irdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ry = 1'b0; in_valid = 1'b1; in_data = 18'(100 + sent);
            @(negedge clk);
            if (!cs_n) strobes++;
            if (in_ready) sent++;
            last_irdy = in_ready;
            next_cycle();
        end
        chk("bp accepted", 32'(sent), 32'd4);
        chk("bp in_ready", 32'(last_irdy), 32'd0);
        chk("bp strobes", 32'(strobes), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 40 && seen_done == 0; k++) begin
            ry = 1'b1; in_valid = (sent < 6); in_data = 18'(100 + sent);
            @(negedge clk);
            if (!cs_n && !we_n) begin
                got_addr.push_back(address);
                got_data.push_back(write_data);
            end
            if (in_valid && in_ready) sent++;
            if (done) seen_done = 1;
            next_cycle();
        end
        chk("bp done seen", 32'(seen_done), 32'd1);
        chk("bp strobe count", 32'(got_addr.size()), 32'd6);
        foreach (got_addr[j]) begin
            chk($sformatf("bp addr%0d", j), 32'(got_addr[j]), 32'h40 + 32'(j));
            chk($sformatf("bp data%0d", j), got_data[j], 32'd100 + 32'(j));
        end

        // Reset mid-burst after two of five writes.
        idle_inputs();
        start = 1'b1; base_addr = 8'h00; count = 9'd5;
        next_cycle();
        start = 1'b0;
        sent = 0; strobes = 0;
        for (int k = 0; k < 10 && strobes < 2; k++) begin
            in_valid = 1'b1; in_data = 18'(200 + sent);
            @(negedge clk);
            if (!cs_n) strobes++;
            if (in_ready) sent++;
            next_cycle();
        end
        chk("rst two strobes", 32'(strobes), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst cycle cs_n", 32'(cs_n), 32'd1);
        chk("rst cycle in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst address", 32'(address), 32'd0);
        acc = 0; seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!cs_n) acc++;
            if (done) seen_done++;
            next_cycle();
        end
        chk("post rst strobes", 32'(acc), 32'd0);
        chk("post rst done", 32'(seen_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_result_writer.md
SRAM_RESULT_WRITER -- requirements
Module: sram_result_writer

Interface
REQ-001 SHALL have parameter RES_W, default 18, width of one result word.
REQ-002 SHALL have parameter MEM_W, default 32, SRAM data width; RES_W <= MEM_W.
REQ-003 SHALL have parameter ADDR_W, default 8, SRAM address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, input buffer depth.
REQ-005 SHALL have parameter SIGN_EXT, default 0; 0 zero-extends and 1 sign-extends a result to MEM_W.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1.
REQ-007 SHALL have ports: start input 1, begin burst; base_addr input ADDR_W, first address; count input ADDR_W+1, words in burst.
REQ-008 SHALL have ports: in_valid input 1; in_ready output 1; in_data input RES_W, result stream.
REQ-009 SHALL have ports: rd_req input 1; rd_addr input ADDR_W; rd_valid output 1; rd_data output MEM_W, readback.
REQ-010 SHALL have ports: busy output 1; done output 1, one-cycle burst-complete pulse.
REQ-011 SHALL have ports: cs_n output 1; we_n output 1; address output ADDR_W; write_data output MEM_W; read_data input MEM_W; ry input 1, SRAM ready.

Function
REQ-012 SHALL implement states IDLE, WRITE, READ, READ_WAIT, DONE.
REQ-013 In IDLE, start=1 SHALL latch base_addr into the address pointer and count into the remaining counter, then enter WRITE; if count=0, enter DONE instead.
REQ-014 In IDLE, rd_req=1 with start=0 SHALL latch rd_addr and enter READ; start=1 wins when both are asserted.
REQ-015 start and rd_req outside IDLE SHALL be ignored.
REQ-016 A result SHALL be accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-017 in_ready SHALL be 1 only in WRITE, while the FIFO is not full and accepted words are fewer than the latched count.
REQ-018 In WRITE, when the FIFO is non-empty and ry=1, the block SHALL drive one strobe cycle.
  - Strobe: cs_n=0, we_n=0, address=pointer, write_data=extended FIFO head.
  - Same cycle: pop the FIFO, increment the pointer modulo 2^ADDR_W, decrement remaining.
REQ-019 A FIFO push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-020 When remaining reaches 0 after a strobe, the block SHALL enter DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-021 The address pointer SHALL wrap from 2^ADDR_W-1 to 0 with no error.
REQ-022 READ SHALL wait for ry=1, then drive one strobe cycle (cs_n=0, we_n=1, address=latched rd_addr) and enter READ_WAIT.
REQ-023 READ_WAIT SHALL wait for ry=1, then register read_data into rd_data, pulse rd_valid for one cycle, and return to IDLE.
REQ-024 Minimum read latency SHALL be 3 cycles from rd_req to rd_valid, given ry=1.
REQ-025 rd_data SHALL hold its value until the next read completes.
REQ-026 Outside strobe cycles, cs_n=1, we_n=1, and address/write_data SHALL hold their last values.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Write throughput SHALL be one word per cycle while ry=1 and the FIFO is non-empty.

Reset
REQ-029 On rst=1 the block SHALL enter IDLE, empty the FIFO, and clear the pointer and counters.
REQ-030 On rst=1 outputs SHALL be: cs_n=1, we_n=1, address=0, write_data=0, rd_data=0, rd_valid=0, done=0, busy=0, in_ready=0.
REQ-031 Reset mid-burst or mid-read SHALL abandon the operation with no further strobe and no done or rd_valid pulse.

Structure
REQ-032 The state encoding type and the extension-mode constants SHALL live in the shared package sram_pkg.
REQ-033 The input buffer SHALL be one sub-module, sync_fifo, parametrised by width RES_W and depth FIFO_DEPTH, with full/empty flags.

Verification
REQ-034 Burst: base_addr=8'hFE, count=4, data 1,2,3,4, ry=1 -> writes to FE,FF,00,01; done 1 cycle after 4th strobe.
REQ-035 Extension: SIGN_EXT=1, in_data=18'h20000 -> write_data=32'hFFFE0000; SIGN_EXT=0 -> 32'h00020000.
REQ-036 Backpressure: ry=0 for 10 cycles with in_valid=1 -> no strobe, in_ready=0 after FIFO_DEPTH accepts; resume with no data loss.
REQ-037 Readback: rd_req, rd_addr=8'h10, SRAM returns 32'hCAFEF00D -> rd_valid on cycle 3, rd_data=32'hCAFEF00D.
REQ-038 count=0 -> done on next cycle with no strobe; start during WRITE -> ignored.
REQ-039 rst asserted mid-burst after 2 of 5 writes -> no further strobe, busy=0 on the next cycle, no done pulse.
